tristate_buffer: RTL and testbench
==================================

Name: tristate_buffer

Overview:
- Single-driver tri-state output stage: drives `y` with data `a` when enable `c` is high, otherwise releases `y` to high impedance.
- Sits at the edge of a shared bus or pad.
- Data/enable path is purely combinational with zero latency.
- A small clocked monitor tracks the enable for debug and bus-occupancy statistics.

Parameters:
- WIDTH, 1, bit width of `a` and `y`.
- PER_BIT_EN, 0, 0: `c` is 1 bit and gates all bits; 1: `c` is WIDTH bits and gates each bit independently.
- CNT_W, 16, width of the enable-assertion counter.

Ports:
- clk  input  1  monitor clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  data to drive.
- c  input  1 (PER_BIT_EN=0) or WIDTH (PER_BIT_EN=1)  output enable, active high.
- y  output (tri)  WIDTH  buffered output; high-Z when not enabled.
- en_q  output  1  registered OR-reduction of `c`: the bus was driven at the last clock edge.
- assert_cnt  output  CNT_W  saturating count of `c` rising edges.

Behaviour:
- Drive rule, per bit i (enable = `c` or `c[i]`):
  - rst=0 and enable=1 -> `y[i]` = `a[i]`.
  - rst=0 and enable=0 -> `y[i]` = Z.
- Reset: rst=1 forces all `y` bits to Z immediately (asynchronous), so no bus contention while reset is held.
- Path timing: combinational, no clock involvement, zero cycle latency; `y` follows `a` and `c` within the same delta.
- Unknown enable: enable X or Z -> `y[i]` = X in simulation. `a` X with enable=1 -> `y[i]` = X.
- `y` must be the only driver inside the block. No pull-up or keeper; a released line reads Z.
- Monitor: sample en_any = OR-reduction of `c`.
  - Register en_prev on every rising clk edge.
  - en_q = en_prev.
- Counter: on each clk edge where en_any=1 and en_prev=0, assert_cnt increments by 1.
  - Saturates at 2^CNT_W-1; no wrap-around.
- Monitor reset values: rst=1 clears en_prev, en_q and assert_cnt to 0 asynchronously.
  - The first edge after reset with en_any=1 counts as an assertion.
- Reset mid-operation: `y` goes to Z and counters clear at once. On release, `y` resumes following `c`/`a` with no clock needed.
- Monitor outputs never affect `y`.

Decomposition:
- No shared package required; the parameters are local.
- One natural sub-module, tristate_monitor: the en_prev register and the saturating counter (clk, rst, en_any -> en_q, assert_cnt).
- The top holds the per-bit conditional-drive generate loop.

Test Plan:
- WIDTH=1, rst=0: a=0,c=0 -> y===Z; a=0,c=1 -> y===0; a=1,c=0 -> y===Z; a=1,c=1 -> y===1. Each checked after a 100-time-unit settle; identity checks, so Z and X are distinguished.
- rst=1 with a=1,c=1 -> y===Z, en_q=0, assert_cnt=0. Deassert rst -> y===1 with no clk edge.
- Toggle c 0->1->0->1 across 4 clk edges -> assert_cnt=2; en_q tracks c delayed by one edge.
- CNT_W=2: 5 assertions -> assert_cnt saturates at 3.
- WIDTH=8, PER_BIT_EN=1: a=8'hA5, c=8'h0F -> y===8'bzzzz0101. Same vector with c=8'h00 -> all Z.
- c=1'bx, a=1 -> y===X; then c=0 -> y===Z.

Source files
------------

// File: rtl/tristate_buffer_pkg.sv
// Shared definitions for the tri-state output stage and its enable monitor.
package tristate_buffer_pkg;

  // Default configuration: one data bit, a single shared enable, and a
  // 16-bit assertion counter.
  localparam int DEFAULT_WIDTH      = 1;
  localparam int DEFAULT_PER_BIT_EN = 0;
  localparam int DEFAULT_CNT_W      = 16;

  // Width of the enable port. When enables are per bit there is one per data
  // bit; otherwise a single enable gates the whole bus.
  function automatic int en_width(input int width, input int per_bit_en);
    return (per_bit_en != 0) ? width : 1;
  endfunction

endpackage

// File: rtl/tristate_monitor.sv
// Debug monitor for the output enable: registers the "bus driven" flag and
// counts rising edges of the enable with a saturating counter.
module tristate_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_any,
  output logic             en_q,
  output logic [CNT_W-1:0] assert_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic en_prev;
  logic rise;
  logic at_max;

  // A new assertion is an enabled sample following a disabled one. en_prev
  // is 0 out of reset, so the first enabled edge after reset counts.
  assign rise   = en_any & ~en_prev;
  assign at_max = &assert_cnt;

  // Remember the enable seen at the previous edge.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_prev <= 1'b0;
    end else begin
      en_prev <= en_any;
    end
  end

  // Count enable rising edges, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      assert_cnt <= '0;
    end else if (rise && !at_max) begin
      assert_cnt <= assert_cnt + CNT_ONE;
    end
  end

  assign en_q = en_prev;

endmodule

// File: rtl/tristate_buffer.sv
// Single-driver tri-state output stage for a shared bus or pad. The data path
// is purely combinational; a small clocked monitor observes the enable only.
module tristate_buffer
  import tristate_buffer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PER_BIT_EN = DEFAULT_PER_BIT_EN,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [WIDTH-1:0]                       a,
  input  logic [en_width(WIDTH, PER_BIT_EN)-1:0] c,
  output tri   [WIDTH-1:0]                       y,
  output logic                                   en_q,
  output logic [CNT_W-1:0]                       assert_cnt
);

  logic en_any;

  // The bus counts as driven when any enable bit is high.
  assign en_any = |c;

  // Per-bit conditional drive; y has no other driver, pull or keeper here.
  for (genvar i = 0; i < WIDTH; i++) begin : g_drive
    logic bit_en;

    if (PER_BIT_EN != 0) begin : g_per_bit
      assign bit_en = c[i];
    end else begin : g_shared
      assign bit_en = c[0];
    end

    // Reset overrides the enable without any clock so the pad is released
    // while reset is held.
    // NOTE: an unknown select makes ?: merge a[i] with 'z, so an X/Z enable
    // shows up as X in simulation instead of silently picking a side.
    assign y[i] = (!rst && bit_en) ? a[i] : 1'bz;
  end

  tristate_monitor #(
    .CNT_W (CNT_W)
  ) u_monitor (
    .clk        (clk),
    .rst        (rst),
    .en_any     (en_any),
    .en_q       (en_q),
    .assert_cnt (assert_cnt)
  );

endmodule

// File: tb/tb_tristate_buffer.sv
// Self-checking bench for tristate_buffer. Each buffered output is observed on
// a pull-down net and a pull-up net from two identical instances, so a
// released line (low on one, high on the other) is told apart from a driven one.
module tb_tristate_buffer;

  localparam logic [1:0] C0 = 2'b00;
  localparam logic [1:0] C1 = 2'b01;
  localparam logic [1:0] CZ = 2'b10;
  localparam logic [1:0] CX = 2'b11;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       a1    = 1'b0;
  logic       c1    = 1'b0;
  logic [7:0] a8    = 8'h00;
  logic [7:0] c8    = 8'h00;
  logic       a_sat = 1'b0;
  logic       c_sat = 1'b0;

  tri0       y1_lo;
  tri1       y1_hi;
  tri0 [7:0] y8_lo;
  tri1 [7:0] y8_hi;
  tri0       y_sat;

  logic        en_q1_lo, en_q1_hi, en_q8_lo, en_q8_hi, en_q_sat;
  logic [15:0] cnt1_lo, cnt1_hi, cnt8_lo, cnt8_hi;
  logic [1:0]  cnt_sat;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  tristate_buffer #(.WIDTH(1), .PER_BIT_EN(0), .CNT_W(16)) u1_lo (
    .clk(clk), .rst(rst), .a(a1), .c(c1), .y(y1_lo), .en_q(en_q1_lo), .assert_cnt(cnt1_lo));
  tristate_buffer #(.WIDTH(1), .PER_BIT_EN(0), .CNT_W(16)) u1_hi (
    .clk(clk), .rst(rst), .a(a1), .c(c1), .y(y1_hi), .en_q(en_q1_hi), .assert_cnt(cnt1_hi));
  tristate_buffer #(.WIDTH(8), .PER_BIT_EN(1), .CNT_W(16)) u8_lo (
    .clk(clk), .rst(rst), .a(a8), .c(c8), .y(y8_lo), .en_q(en_q8_lo), .assert_cnt(cnt8_lo));
  tristate_buffer #(.WIDTH(8), .PER_BIT_EN(1), .CNT_W(16)) u8_hi (
    .clk(clk), .rst(rst), .a(a8), .c(c8), .y(y8_hi), .en_q(en_q8_hi), .assert_cnt(cnt8_hi));
  tristate_buffer #(.WIDTH(1), .PER_BIT_EN(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .a(a_sat), .c(c_sat), .y(y_sat), .en_q(en_q_sat), .assert_cnt(cnt_sat));

  // Encode one observed line from its pull-down and pull-up views.
  function automatic logic [1:0] code_of(input logic lo, input logic hi);
    if (lo === 1'b0 && hi === 1'b1) return CZ;
    if (lo === hi && lo === 1'b1) return C1;
    if (lo === hi && lo === 1'b0) return C0;
    return CX;
  endfunction

  function automatic logic [31:0] obs1(input logic lo, input logic hi);
    return {30'b0, code_of(lo, hi)};
  endfunction

  function automatic logic [31:0] obs8(input logic [7:0] lo, input logic [7:0] hi);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = code_of(lo[i], hi[i]);
    return r;
  endfunction

  // Expected line values written MSB first as a string of 0/1/z/x.
  function automatic logic [31:0] enc(input string s);
    logic [31:0] r = '0;
    int n = s.len();
    for (int i = 0; i < n; i++) begin
      byte ch = s[i];
      int  b  = n - 1 - i;
      case (ch)
        "0":     r[2*b +: 2] = C0;
        "1":     r[2*b +: 2] = C1;
        "z":     r[2*b +: 2] = CZ;
        default: r[2*b +: 2] = CX;
      endcase
    end
    return r;
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    logic [1:0]  tt_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    string       tt_exp [4] = '{"z", "0", "z", "1"};
    logic        seq    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        model_prev;
    logic [15:0] model_cnt;
    logic        probe;
    bit          four_state;

    // Reset held with the enable asserted: line released, monitor cleared.
    a1 = 1'b1;
    c1 = 1'b1;
    push("rst_y", enc("z"));
    #17;
    check(obs1(y1_lo, y1_hi));
    push("rst_en_q", 32'h0);
    check({30'b0, en_q1_lo, en_q1_hi});
    push("rst_cnt", 32'h0);
    check({cnt1_lo, cnt1_hi});

    // Release between clock edges: y follows a at once, no edge needed.
    @(negedge clk);
    rst = 1'b0;
    push("release_y", enc("1"));
    #1;
    check(obs1(y1_lo, y1_hi));
    c1 = 1'b0;

    // Drive truth table with identity checks after a long settle.
    for (int i = 0; i < 4; i++) begin
      {a1, c1} = tt_in[i];
      push($sformatf("tt_a%0b_c%0b", tt_in[i][1], tt_in[i][0]), enc(tt_exp[i]));
      #100;
      check(obs1(y1_lo, y1_hi));
    end

    // Reset mid-operation: line released and monitor cleared immediately.
    @(negedge clk);
    rst = 1'b1;
    push("midrst_y", enc("z"));
    push("midrst_en_q", 32'h0);
    push("midrst_cnt", 32'h0);
    #1;
    check(obs1(y1_lo, y1_hi));
    check({30'b0, en_q1_lo, en_q1_hi});
    check({cnt1_lo, cnt1_hi});
    c1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Enable toggling across four edges; the first enabled edge counts.
    model_prev = 1'b0;
    model_cnt  = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      c1 = seq[k];
      if (seq[k] && !model_prev) model_cnt = model_cnt + 16'd1;
      model_prev = seq[k];
      push($sformatf("mon_en_q_%0d", k), {30'b0, seq[k], seq[k]});
      push($sformatf("mon_cnt_%0d", k), {model_cnt, model_cnt});
      @(posedge clk);
      #1;
      check({30'b0, en_q1_lo, en_q1_hi});
      check({cnt1_lo, cnt1_hi});
    end

    // Two-bit counter: five assertions saturate at 3 and hold there.
    a_sat = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      c_sat = 1'b1;
      push($sformatf("sat_y_%0d", k), 32'h1);
      #1;
      check({31'b0, y_sat});
      push($sformatf("sat_cnt_%0d", k), (k >= 2) ? 32'd3 : 32'(k + 1));
      @(posedge clk);
      #1;
      check({30'b0, cnt_sat});
      @(negedge clk);
      c_sat = 1'b0;
    end
    push("sat_en_q_low", 32'h0);
    @(posedge clk);
    #1;
    check({31'b0, en_q_sat});

    // Eight bits with independent enables.
    @(negedge clk);
    a8 = 8'hA5;
    c8 = 8'h0F;
    push("pb_0f", enc("zzzz0101"));
    #1;
    check(obs8(y8_lo, y8_hi));
    push("pb_mon_en_q", 32'h3);
    push("pb_mon_cnt", {16'd1, 16'd1});
    @(posedge clk);
    #1;
    check({30'b0, en_q8_lo, en_q8_hi});
    check({cnt8_lo, cnt8_hi});
    @(negedge clk);
    c8 = 8'hF0;
    push("pb_f0", enc("1010zzzz"));
    #1;
    check(obs8(y8_lo, y8_hi));
    push("pb_mon_cnt_hold", {16'd1, 16'd1});
    @(posedge clk);
    #1;
    check({cnt8_lo, cnt8_hi});
    @(negedge clk);
    c8 = 8'h00;
    push("pb_00", enc("zzzzzzzz"));
    #1;
    check(obs8(y8_lo, y8_hi));
    push("pb_mon_en_q_low", 32'h0);
    @(posedge clk);
    #1;
    check({30'b0, en_q8_lo, en_q8_hi});

    // Unknown enable: only a four-state simulator can represent X on y.
    probe      = 1'bx;
    four_state = $isunknown(probe);
    @(negedge clk);
    a1 = 1'b1;
    c1 = 1'bx;
    #1;
    if (four_state) begin
      push("x_enable", enc("x"));
      check(obs1(y1_lo, y1_hi));
    end
    c1 = 1'b0;
    push("x_then_off", enc("z"));
    #1;
    check(obs1(y1_lo, y1_hi));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
